// File: rtl/ps2_pkg.sv
// Shared FSM encoding, bit-counter width and parity helper for the PS/2 host transmitter.
// Latency and backpressure: not applicable (types and functions only).
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_BITS,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    // Counts device clock falling edges 0..10 while the frame is shifted out.
    localparam int BIT_CNT_W = 4;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line synchronizer: two flops per line plus falling-edge detect on the clock line.
// Latency: 2 clk to clk_s/data_s; clk_fall is high for the one cycle in which clk_s first reads low.
// Backpressure: none, free-running.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_s,
    output logic data_s,
    output logic clk_fall
);
    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Flops reset high so an idle bus never produces a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            data_ff  <= {data_ff[0], ps2_data_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s    = clk_ff[1];
    assign data_s   = data_ff[1];
    assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-clock frame, ack); PS2_TX_ACK_CHECK_EN turns a missing ack into err.
// Latency: INHIBIT_CYCLES + 1 clk before the device is clocked, then paced by the device clock, bounded by TIMEOUT_CYCLES.
// Backpressure: tx_ready only in IDLE; tx_valid is ignored while busy, nothing is queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    ps2_state_t           state;
    logic [7:0]           tx_q;
    logic [31:0]          inh_cnt;
    logic [31:0]          to_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 clk_s;
    logic                 data_s;
    logic                 clk_fall;
    logic                 timeout;
`ifdef PS2_TX_ACK_CHECK_EN
    logic                 ack_q;
`endif

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fall   (clk_fall)
    );

    assign timeout = (to_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tx_q        <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_q        <= tx_data;
                        inh_cnt     <= '0;
                        state       <= ST_INHIBIT;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt == 32'(INHIBIT_CYCLES - 1)) begin
                        state       <= ST_START;
                        ps2_data_oe <= 1'b1;
                    end else begin
                        inh_cnt <= inh_cnt + 32'd1;
                    end
                end
                ST_START: begin
                    // Releasing the clock with data low is the request-to-send.
                    state      <= ST_BITS;
                    ps2_clk_oe <= 1'b0;
                    bit_cnt    <= '0;
                    to_cnt     <= '0;
                end
                ST_BITS, ST_ACK, ST_WAIT_IDLE: begin
                    if (timeout) begin
                        state       <= ST_IDLE;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        busy        <= 1'b0;
                        tx_ready    <= 1'b1;
                        err         <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                        if (state == ST_BITS && clk_fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 4'd8) begin
                                ps2_data_oe <= ~tx_q[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_data_oe <= ~odd_parity(tx_q);
                            end else begin
                                ps2_data_oe <= 1'b0;
                                state       <= ST_ACK;
                            end
                        end else if (state == ST_ACK && clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            ack_q <= ~data_s;
`endif
                            state <= ST_WAIT_IDLE;
                        end else if (state == ST_WAIT_IDLE && clk_s && data_s) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
`ifdef PS2_TX_ACK_CHECK_EN
                            if (ack_q) begin
                                done <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
`else
                            done <= 1'b1;
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus with a clocking device model and a frame reference model.
module tb_ps2_host_tx;
    localparam int INH  = 10;
    localparam int TMO  = 200;
    localparam int HALF = 6;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    wire        ps2_clk_line  = ~ps2_clk_oe & ~dev_clk_low;
    wire        ps2_data_line = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Passive monitor, sampled on the falling edge.
    int   cyc = 0, inh_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
    int   both_viol = 0, rdy_busy_viol = 0, acc_cnt = 0;
    int   last_done_cyc = 0, last_err_cyc = 0, last_acc_cyc = 0, start_exit_cyc = 0;
    logic [1:0] err_oe = 2'b11;
    logic rdy_after_err = 1'b0, prev_start = 1'b0, prev_err = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt <= inh_cnt + 1;
        if (ps2_clk_oe && ps2_data_oe) start_cnt <= start_cnt + 1;
        prev_start <= ps2_clk_oe && ps2_data_oe;
        if (prev_start && !ps2_clk_oe) start_exit_cyc <= cyc;
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (err) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
            err_oe       <= {ps2_clk_oe, ps2_data_oe};
        end
        prev_err <= err;
        if (prev_err) rdy_after_err <= tx_ready;
        if (done && err) both_viol <= both_viol + 1;
        if (tx_ready && busy) rdy_busy_viol <= rdy_busy_viol + 1;
    end

    // Handshakes complete on the rising edge, so count them there.
    always @(posedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame as seen on the wire at device rising edges 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] exp_frame(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            if (b[i]) ones++;
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!tx_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send, then generates npulses clocks, reading data before each rise.
    task automatic device_xfer(input int npulses, input bit ack, output logic [9:0] bits, output bit seen);
        bits = '0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) seen = 1'b1;
        end
        if (!seen) return;
        repeat (2) @(negedge clk);
        for (int p = 1; p <= npulses; p++) begin
            if (p == 11 && ack) begin
                dev_data_low = 1'b1;
                @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (p <= 10) bits[p-1] = ps2_data_line;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack, output logic [9:0] bits,
                            output bit seen, output int dd, output int de);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b);
        device_xfer(11, ack, bits, seen);
        repeat (20) @(negedge clk);
        dd = done_cnt - d0;
        de = err_cnt - e0;
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       exp_par;
        bit         exp_done;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        logic [9:0] bits, bits2;
        bit         seen, seen2, ok_done;
        int         dd, de, d0, e0, a0, i0, s0, w;
        logic [7:0] rb;
        bit         rack;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'hF4, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, !ACK_CHECK};

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(tx_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            i0 = inh_cnt;
            s0 = start_cnt;
            run_xfer(vecs[v].data, vecs[v].ack, bits, seen, dd, de);
            check("tbl_request", 32'(seen), 32'd1);
            check("tbl_inhibit_len", inh_cnt - i0, INH);
            check("tbl_start_len", start_cnt - s0, 1);
            check("tbl_data_bits", 32'(bits[7:0]), 32'(vecs[v].data));
            check("tbl_parity", 32'(bits[8]), 32'(vecs[v].exp_par));
            check("tbl_stop", 32'(bits[9]), 32'd1);
            check("tbl_frame_model", 32'(bits), 32'(exp_frame(vecs[v].data)));
            check("tbl_done", dd, 32'(vecs[v].exp_done));
            check("tbl_err", de, 32'(!vecs[v].exp_done));
        end

        for (int r = 0; r < 8; r++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            ok_done = rack || !ACK_CHECK;
            run_xfer(rb, rack, bits, seen, dd, de);
            check("rnd_frame", 32'(bits), 32'(exp_frame(rb)));
            check("rnd_done", dd, 32'(ok_done));
            check("rnd_err", de, 32'(!ok_done));
        end

        // Device never clocks: the transfer must time out.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h3C);
        repeat (TMO + 40) @(negedge clk);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_no_done", done_cnt - d0, 0);
        check("tmo_latency", last_err_cyc - start_exit_cyc, TMO);
        check("tmo_oe_released", 32'(err_oe), 32'd0);
        check("tmo_ready_next", 32'(rdy_after_err), 32'd1);

        // Reset after the fifth device clock edge.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        device_xfer(5, 1'b0, bits, seen);
        check("rst_request", 32'(seen), 32'd1);
        check("rst_first_bits", 32'(bits[4:0]), 32'h05);
        check("rst_busy_mid", 32'(busy), 32'd1);
        check("rst_data_oe_mid", 32'(ps2_data_oe), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_oe_immediate", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("rst_status", 32'({tx_ready, busy}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_err", err_cnt - e0, 0);
        run_xfer(8'hF4, 1'b1, bits, seen, dd, de);
        check("post_rst_frame", 32'(bits), 32'(exp_frame(8'hF4)));
        check("post_rst_done", dd, 1);
        check("post_rst_err", de, 0);

        // tx_valid held across a transfer: the next byte waits for done.
        d0 = done_cnt;
        a0 = acc_cnt;
        w  = 0;
        while (!tx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        device_xfer(11, 1'b1, bits, seen);
        tx_data = 8'h69;
        w = 0;
        while (acc_cnt - a0 < 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        tx_valid = 1'b0;
        tx_data  = 8'h3C;
        check("hold_two_accepts", acc_cnt - a0, 2);
        check("hold_first_done", done_cnt - d0, 1);
        check("hold_accept_after_done", 32'(last_acc_cyc > last_done_cyc), 32'd1);
        device_xfer(11, 1'b1, bits2, seen2);
        repeat (20) @(negedge clk);
        check("hold_frame1", 32'(bits), 32'(exp_frame(8'h96)));
        check("hold_frame2", 32'(bits2), 32'(exp_frame(8'h69)));
        check("hold_total_done", done_cnt - d0, 2);

        check("ready_never_with_busy", rdy_busy_viol, 0);
        check("done_err_exclusive", both_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
